// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequential divider: FSM encodings, default width,
// and the divide-by-zero quotient pattern.
package alu_pkg;
    localparam int ALU_DIV_WIDTH_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Sliced down to WIDTH by the user; covers widths up to 128 bits.
    localparam logic [127:0] DIV0_QUOT = '1;
endpackage

// File: rtl/alu_div_step.sv
// One combinational restoring-division step built on the a + ~b + 1 adder path;
// a negative trial is restored by selecting the pre-trial value.
module alu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);
    logic [WIDTH:0]   a_w;
    logic [WIDTH:0]   b_w;
    logic [WIDTH+1:0] sum;
    logic             unused_msb;

    assign a_w = {rem_i, bit_i};
    assign b_w = {1'b0, dvs_i};
    // Carry out of the extended adder is the "no borrow" flag.
    assign sum = {1'b0, a_w} + {1'b0, ~b_w} + {{(WIDTH+1){1'b0}}, 1'b1};

    assign qbit_o     = sum[WIDTH+1];
    assign rem_o      = qbit_o ? sum[WIDTH-1:0] : a_w[WIDTH-1:0];
    assign unused_msb = sum[WIDTH] ^ a_w[WIDTH];
endmodule

// File: rtl/alu_divider_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional signed mode: define ALU_DIV_SIGNED_EN to add the op_signed port.
module alu_divider_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_DIV_SIGNED_EN
    input  logic             op_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] rem_nxt, q_raw, a_mag, b_mag, q_fix, r_fix;
    logic             qbit;

`ifdef ALU_DIV_SIGNED_EN
    logic qneg_q, qneg_d, rneg_q, rneg_d, a_neg, b_neg;
    assign a_neg = op_signed & dividend[WIDTH-1];
    assign b_neg = op_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    assign q_fix = qneg_q ? -q_raw : q_raw;
    assign r_fix = rneg_q ? -rem_nxt : rem_nxt;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fix = q_raw;
    assign r_fix = rem_nxt;
`endif

    alu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (rem_nxt),
        .qbit_o (qbit)
    );

    // Quotient bits shift into the bottom of the dividend register as it drains.
    assign q_raw = {dvd_q[WIDTH-2:0], qbit};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
`ifdef ALU_DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quo_d   = DIV0_QUOT[WIDTH-1:0];
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        rem_d   = '0;
                        cnt_d   = '0;
                        quo_d   = '0;
                        rmd_d   = '0;
                        dbz_d   = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
`endif
                    end
                end
            end
            ST_RUN: begin
                rem_d = rem_nxt;
                dvd_d = q_raw;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = ST_DONE;
                    quo_d   = q_fix;
                    rmd_d   = r_fix;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef ALU_DIV_SIGNED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`endif

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_divider_seq.sv
// Directed self-checking bench for alu_divider_seq (WIDTH=32).
module tb_alu_divider_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_divider_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef ALU_DIV_SIGNED_EN
        .op_signed   (op_signed),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Stimulus helper: pulses start, scrambles operands afterwards, then waits for done.
    // lat counts negedges after the accepting edge; -1 means the bound expired.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output int lat, output int busy_cnt, output bit overlap);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; op_signed = sgn;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; op_signed = 1'b0;
        lat = 1; busy_cnt = 0; overlap = 1'b0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy && done) overlap = 1'b1;
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_div_zero();
        int bcnt = 0;
        @(negedge clk);
        start = 1'b1; dividend = 32'd5; divisor = 32'd0;
        @(negedge clk);
        // Still high with new operands while in DONE: must be ignored.
        dividend = 32'd50; divisor = 32'd5;
        if (busy) bcnt++;
        checks++;
        if (done !== 1'b1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL div0_result: done=%b q=%h r=%h dbz=%b, want 1 ffffffff 00000005 1",
                     done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        start = 1'b0;
        if (busy) bcnt++;
        checks++;
        if (done !== 1'b0 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL div0_hold: done=%b q=%h r=%h dbz=%b, want 0 ffffffff 00000005 1",
                     done, quotient, remainder, div_by_zero);
        end
        repeat (3) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        checks++;
        if (bcnt !== 0 || quotient !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div0_no_busy: busy_cycles=%0d q=%h, want 0 ffffffff", bcnt, quotient);
        end
    endtask

    task automatic test_basic_latency();
        int lat, bc;
        bit ov;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0; dividend = 32'd0; divisor = 32'd0;
        // The previous divide-by-zero result must be cleared on acceptance.
        checks++;
        if (busy !== 1'b1 || quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL start_clears: busy=%b q=%h r=%h dbz=%b, want 1 0 0 0",
                     busy, quotient, remainder, div_by_zero);
        end
        lat = 1; bc = 0; ov = 1'b0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        if (busy && done) ov = 1'b1;
        checks++;
        if (lat !== 33 || bc !== 32 || ov !== 1'b0) begin
            failures++;
            $display("FAIL lat_100_7: latency=%0d busy_cycles=%0d overlap=%b, want 33 32 0", lat, bc, ov);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL res_100_7: q=%0d r=%0d dbz=%b, want 14 2 0", quotient, remainder, div_by_zero);
        end
        repeat (4) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL hold_idle: done=%b busy=%b q=%0d r=%0d after %0d cycles, want 0 0 14 2",
                     done, busy, quotient, remainder, cyc);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [5] = '{32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'd7, 32'd1000000};
        logic [31:0] vb [5] = '{32'd1, 32'd10, 32'h0001_0000, 32'd7, 32'd1000};
        logic [31:0] eq [5] = '{32'hFFFF_FFFF, 32'd0, 32'h0000_FFFF, 32'd1, 32'd1000};
        logic [31:0] er [5] = '{32'd0, 32'd3, 32'h0000_FFFF, 32'd0, 32'd0};
        int lat, bc;
        bit ov;
        for (int i = 0; i < 5; i++) begin
            run_div(va[i], vb[i], 1'b0, lat, bc, ov);
            checks++;
            if (lat !== 33 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0 || ov) begin
                failures++;
                $display("FAIL vec%0d %h/%h: lat=%0d q=%h r=%h dbz=%b ov=%b, want 33 %h %h 0 0",
                         i, va[i], vb[i], lat, quotient, remainder, div_by_zero, ov, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat = 1;
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL busy_ignore: lat=%0d q=%0d r=%0d, want 33 14 2", lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        bit ov;
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_run: busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_stays_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        run_div(32'd100, 32'd7, 1'b0, lat, bc, ov);
        checks++;
        if (lat !== 33 || bc !== 32 || quotient !== 32'd14 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL after_reset: lat=%0d busy_cycles=%0d q=%0d r=%0d, want 33 32 14 2",
                     lat, bc, quotient, remainder);
        end
    endtask

`ifdef ALU_DIV_SIGNED_EN
    task automatic test_signed();
        int lat, bc;
        bit ov;
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bc, ov);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL signed_m7_2: lat=%0d q=%h r=%h, want 33 fffffffd ffffffff", lat, quotient, remainder);
        end
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc, ov);
        checks++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL signed_ovf: q=%h r=%h dbz=%b, want 80000000 0 0", quotient, remainder, div_by_zero);
        end
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1, lat, bc, ov);
        checks++;
        if (lat !== 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFF9 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL signed_div0: lat=%0d q=%h r=%h dbz=%b, want 1 ffffffff fffffff9 1",
                     lat, quotient, remainder, div_by_zero);
        end
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc, ov);
        checks++;
        if (quotient !== 32'h7FFF_FFFC || remainder !== 32'd1) begin
            failures++;
            $display("FAIL unsigned_mode: q=%h r=%h, want 7ffffffc 00000001", quotient, remainder);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_div_zero();
        test_basic_latency();
        test_vectors();
        test_back_to_back();
        test_reset_mid_run();
`ifdef ALU_DIV_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
